// File: rtl/floppy_track_pkg.sv
// Shared constants and FSM state type for the
// 5.25" nibble-track cache.
package floppy_track_pkg;
  localparam int BLOCK_BYTES = 512;
  localparam int BLOCKS_PER_TRACK = 13;
  localparam int TRACK_BYTES =
    BLOCK_BYTES * BLOCKS_PER_TRACK;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } state_t;
endpackage

// File: rtl/floppy_track_buf_ram.sv
// True dual-port 2**ADDR_W x 8 track RAM.
// Port A faces the CPU, port B faces the SD host.
module track_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_di,
  input  logic              a_we,
  output logic [7:0]        a_do,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_di,
  input  logic              b_we,
  output logic [7:0]        b_do
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk_sys) begin
    if (a_we) mem[a_addr] <= a_di;
    if (b_we) mem[b_addr] <= b_di;
    if (reset) begin
      a_do <= '0;
      b_do <= '0;
    end else begin
      a_do <= mem[a_addr];
      b_do <= mem[b_addr];
    end
  end
endmodule

// File: rtl/floppy_track_buf.sv
// Per-drive nibble-track cache: loads one track
// from the SD image, writes it back when dirty.
module floppy_track_buf #(
  parameter int BLOCKS_PER_TRACK =
    floppy_track_pkg::BLOCKS_PER_TRACK,
  parameter int ADDR_W = 13
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_di,
  output logic [7:0]        ram_do,
  input  logic              ram_we,
  input  logic [5:0]        track,
  output logic              busy,
  input  logic              change,
  input  logic              mount,
  output logic              ready,
  output logic              active,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  output logic [7:0]        sd_buff_din,
  input  logic              sd_buff_wr,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack
);
  import floppy_track_pkg::*;

  state_t      state_q, state_d;
  logic        change_q, ack_q;
  logic [5:0]  ld_trk, req_trk;
  logic        trk_valid, dirty, abort_q;
  logic [3:0]  blk;
  logic        change_evt, ack_rise, ack_fall;
  logic        abort_now, mismatch, last_blk;
  logic        cpu_we, sd_we, reading;
  logic [31:0] b_off;

  assign change_evt = change ^ change_q;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;
  assign abort_now  = abort_q | change_evt;
  assign mismatch   = ~trk_valid | (track != ld_trk);
  assign last_blk   =
    blk == 4'(BLOCKS_PER_TRACK - 1);
  assign cpu_we     = ram_we & ready & ~busy;
  assign reading    =
    (state_q == RD_REQ) | (state_q == RD_WAIT);
  assign active     = sd_rd | sd_wr |
    (state_q == WR_WAIT) | (state_q == RD_WAIT);

  assign b_off = 32'(blk) * 32'(BLOCK_BYTES) +
    32'(sd_buff_addr);
  assign sd_we = sd_buff_wr & sd_ack & reading &
    (b_off < 32'(TRACK_BYTES));

  track_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_sys (clk_sys),
    .reset   (reset),
    .a_addr  (ram_addr),
    .a_di    (ram_di),
    .a_we    (cpu_we),
    .a_do    (ram_do),
    .b_addr  (b_off[ADDR_W-1:0]),
    .b_di    (sd_buff_dout),
    .b_we    (sd_we),
    .b_do    (sd_buff_din)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!change_evt && mount && mismatch)
          state_d = (dirty | cpu_we) ?
            WR_REQ : RD_REQ;
      WR_REQ:
        if (ack_rise) state_d = WR_WAIT;
      WR_WAIT:
        if (ack_fall)
          state_d = abort_now ? IDLE :
            last_blk ? RD_REQ : WR_REQ;
      RD_REQ:
        if (ack_rise) state_d = RD_WAIT;
      RD_WAIT:
        if (ack_fall)
          state_d = (abort_now | last_blk) ?
            IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      change_q  <= 1'b0;
      ack_q     <= 1'b0;
      ld_trk    <= '0;
      req_trk   <= '0;
      trk_valid <= 1'b0;
      dirty     <= 1'b0;
      abort_q   <= 1'b0;
      blk       <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      sd_lba    <= '0;
    end else begin
      change_q <= change;
      ack_q    <= sd_ack;
      if (cpu_we) dirty <= 1'b1;
      // a swap outside IDLE lets the block finish
      if (change_evt) begin
        trk_valid <= 1'b0;
        dirty     <= 1'b0;
        ready     <= 1'b0;
        if (state_q != IDLE) abort_q <= 1'b1;
      end
      unique case (state_q)
        IDLE:
          if (!mount) ready <= 1'b0;
          else if (!change_evt) begin
            if (mismatch) begin
              busy    <= 1'b1;
              ready   <= 1'b0;
              blk     <= '0;
              req_trk <= track;
            end else begin
              ready <= 1'b1;
            end
          end
        WR_REQ:
          if (ack_rise) sd_wr <= 1'b0;
          else begin
            sd_wr  <= 1'b1;
            sd_lba <= 32'(ld_trk) *
              32'(BLOCKS_PER_TRACK) + 32'(blk);
          end
        WR_WAIT:
          if (ack_fall) begin
            if (abort_now) begin
              busy    <= 1'b0;
              abort_q <= 1'b0;
            end else if (last_blk) begin
              blk   <= '0;
              dirty <= 1'b0;
            end else begin
              blk <= blk + 4'd1;
            end
          end
        RD_REQ: begin
          ld_trk <= req_trk;
          if (!abort_now) trk_valid <= 1'b1;
          if (ack_rise) sd_rd <= 1'b0;
          else begin
            sd_rd  <= 1'b1;
            sd_lba <= 32'(req_trk) *
              32'(BLOCKS_PER_TRACK) + 32'(blk);
          end
        end
        RD_WAIT:
          if (ack_fall) begin
            if (abort_now | last_blk) begin
              busy    <= 1'b0;
              abort_q <= 1'b0;
            end else begin
              blk <= blk + 4'd1;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_floppy_track_buf.sv
// Directed bench for floppy_track_buf with a
// simple SD host model serving block requests.
module tb_floppy_track_buf;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [12:0] ram_addr;
  logic [7:0]  ram_di, ram_do;
  logic        ram_we;
  logic [5:0]  track;
  logic        busy, change, mount, ready, active;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;

  int errors = 0;
  int checks = 0;
  logic [7:0] wcap [13][512];

  floppy_track_buf dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_do       (ram_do),
    .ram_we       (ram_we),
    .track        (track),
    .busy         (busy),
    .change       (change),
    .mount        (mount),
    .ready        (ready),
    .active       (active),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] pat(
    input int lba, input int a);
    return 8'(a) ^ (8'(lba) + 8'h3C);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic read_byte(input logic [12:0] a,
                           output logic [7:0] d);
    ram_addr = a;
    tick();
    d = ram_do;
  endtask

  task automatic write_byte(input logic [12:0] a,
                            input logic [7:0] d);
    ram_addr = a;
    ram_di   = d;
    ram_we   = 1'b1;
    tick();
    ram_we   = 1'b0;
  endtask

  task automatic serve_block(input bit exp_wr,
    input int exp_lba, input int idx,
    output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (!(sd_rd || sd_wr) && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (!(sd_rd || sd_wr)) begin
      $display("FAIL req_timeout lba=%0d", exp_lba);
      errors++;
      return;
    end
    checks++;
    if (sd_wr !== exp_wr || sd_rd !== !exp_wr) begin
      $display("FAIL op lba=%0d rd=%b wr=%b exp_wr=%b",
        exp_lba, sd_rd, sd_wr, exp_wr);
      errors++;
    end
    checks++;
    if (sd_lba !== 32'(exp_lba)) begin
      $display("FAIL lba got=%0d exp=%0d",
        sd_lba, exp_lba);
      errors++;
    end
    sd_ack = 1'b1;
    if (exp_wr) begin
      sd_buff_addr = '0;
      for (int a = 0; a < 512; a++) begin
        tick();
        wcap[idx][a] = sd_buff_din;
        sd_buff_addr = 9'(a + 1);
      end
    end else begin
      for (int a = 0; a < 512; a++) begin
        sd_buff_addr = 9'(a);
        sd_buff_dout = pat(exp_lba, a);
        sd_buff_wr   = 1'b1;
        tick();
      end
      sd_buff_wr = 1'b0;
    end
    sd_ack = 1'b0;
    ok = 1'b1;
  endtask

  task automatic serve_load(input bit exp_wr,
                            input int base);
    bit ok;
    for (int i = 0; i < 13; i++) begin
      serve_block(exp_wr, base + i, i, ok);
      if (!ok) return;
    end
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_last_fall got=%b exp=1",
        busy);
      errors++;
    end
  endtask

  task automatic check_ready(input string nm);
    tick(2);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL %s ready=%b busy=%b exp 1/0",
        nm, ready, busy);
      errors++;
    end
  endtask

  task automatic check_byte(input string nm,
    input logic [12:0] a, input logic [7:0] exp);
    logic [7:0] d;
    read_byte(a, d);
    checks++;
    if (d !== exp) begin
      $display("FAIL %s got=%h exp=%h", nm, d, exp);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mount = 1'b0;
    track = '0;
    change = 1'b0;
    ram_addr = '0;
    ram_di = '0;
    ram_we = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick(3);
    checks++;
    if ({busy, ready, active, sd_rd, sd_wr}
        !== 5'b0) begin
      $display("FAIL reset_flags got=%b exp=00000",
        {busy, ready, active, sd_rd, sd_wr});
      errors++;
    end
    checks++;
    if (sd_lba !== 32'd0) begin
      $display("FAIL reset_lba got=%h exp=0", sd_lba);
      errors++;
    end
    checks++;
    if (ram_do !== 8'h00 || sd_buff_din !== 8'h00)
    begin
      $display("FAIL reset_data do=%h din=%h exp=0",
        ram_do, sd_buff_din);
      errors++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_initial_load();
    mount = 1'b1;
    track = 6'd0;
    serve_load(1'b0, 0);
    check_ready("ready_trk0");
    check_byte("blk0_b511", 13'h1FF, pat(0, 511));
    check_byte("blk12_b0", 13'h1800, pat(12, 0));
  endtask

  task automatic test_writeback();
    write_byte(13'h0205, 8'hA5);
    check_byte("cpu_wr_rb", 13'h0205, 8'hA5);
    track = 6'd1;
    serve_load(1'b1, 0);
    checks++;
    if (wcap[1][5] !== 8'hA5) begin
      $display("FAIL wb_dirty got=%h exp=a5",
        wcap[1][5]);
      errors++;
    end
    checks++;
    if (wcap[0][0] !== pat(0, 0)) begin
      $display("FAIL wb_b0 got=%h exp=%h",
        wcap[0][0], pat(0, 0));
      errors++;
    end
    checks++;
    if (wcap[12][511] !== pat(12, 511)) begin
      $display("FAIL wb_b12 got=%h exp=%h",
        wcap[12][511], pat(12, 511));
      errors++;
    end
    serve_load(1'b0, 13);
    check_ready("ready_trk1");
    check_byte("trk1_rd", 13'h0205, pat(14, 5));
  endtask

  task automatic test_track_change();
    track = 6'd5;
    serve_load(1'b0, 65);
    check_ready("ready_trk5");
    check_byte("trk5_rd", 13'h0000, pat(65, 0));
  endtask

  task automatic test_change();
    write_byte(13'h0100, 8'h5A);
    change = ~change;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      $display("FAIL change_ready got=%b exp=0",
        ready);
      errors++;
    end
    serve_load(1'b0, 65);
    check_ready("ready_reload");
    check_byte("reload_rd", 13'h0100, pat(65, 256));
  endtask

  task automatic test_unmount();
    bit seen;
    seen  = 1'b0;
    mount = 1'b0;
    tick(2);
    checks++;
    if (ready !== 1'b0) begin
      $display("FAIL unmount_ready got=%b exp=0",
        ready);
      errors++;
    end
    track = 6'd9;
    write_byte(13'h0010, 8'h77);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sd_rd || sd_wr) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      $display("FAIL unmount_req got=1 exp=0");
      errors++;
    end
    check_byte("unmount_rb", 13'h0010, pat(65, 16));
  endtask

  task automatic test_reset_mid();
    int t;
    t = 0;
    track = 6'd2;
    mount = 1'b1;
    while (!sd_rd && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (sd_lba !== 32'd26 || sd_rd !== 1'b1) begin
      $display("FAIL mid_req lba=%0d rd=%b exp 26/1",
        sd_lba, sd_rd);
      errors++;
    end
    sd_ack = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b1 || active !== 1'b1) begin
      $display("FAIL mid_busy busy=%b act=%b exp 1/1",
        busy, active);
      errors++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({sd_rd, busy, ready} !== 3'b000) begin
      $display("FAIL mid_reset got=%b exp=000",
        {sd_rd, busy, ready});
      errors++;
    end
    reset  = 1'b0;
    sd_ack = 1'b0;
    tick();
    serve_load(1'b0, 26);
    check_ready("ready_after_rst");
  endtask

  initial begin
    test_reset();
    test_initial_load();
    test_writeback();
    test_track_change();
    test_change();
    test_unmount();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end
endmodule
